// File: rtl/serial_subtractor_if.sv
// Start/busy/done bundle for the bit-serial subtractor.
// master drives start/a/b/bin; slave returns busy/done/diff/bout(/ovf).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
`else
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// LSB-first serial subtractor: diff = a - b - bin over WIDTH cycles.
// Ports: clk, rst (sync, high), bus (slave). Option: SERIAL_SUB_OVF_EN adds ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sa_q, sa_n;
  logic [WIDTH-1:0] sb_q, sb_n;
  logic [WIDTH-1:0] sr_q, sr_n;
  logic             br_q, br_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] diff_q, diff_n;
  logic             bout_q, bout_n;
  logic             d;
  logic             bnext;
`ifdef SERIAL_SUB_OVF_EN
  logic             am_q, am_n;
  logic             bm_q, bm_n;
  logic             ovf_q, ovf_n;
`endif

  always_comb begin
    state_n = state_q;
    sa_n    = sa_q;
    sb_n    = sb_q;
    sr_n    = sr_q;
    br_n    = br_q;
    cnt_n   = cnt_q;
    diff_n  = diff_q;
    bout_n  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    am_n    = am_q;
    bm_n    = bm_q;
    ovf_n   = ovf_q;
`endif
    d     = sa_q[0] ^ sb_q[0] ^ br_q;
    bnext = (~sa_q[0] & sb_q[0])
          | (~(sa_q[0] ^ sb_q[0]) & br_q);
    case (state_q)
      IDLE, DONE: begin
        state_n = IDLE;
        if (bus.start) begin
          state_n = SHIFT;
          sa_n    = bus.a;
          sb_n    = bus.b;
          br_n    = bus.bin;
          sr_n    = '0;
          cnt_n   = '0;
`ifdef SERIAL_SUB_OVF_EN
          am_n    = bus.a[WIDTH-1];
          bm_n    = bus.b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        sa_n  = sa_q >> 1;
        sb_n  = sb_q >> 1;
        br_n  = bnext;
        // result enters at the MSB so it is aligned after WIDTH shifts
        sr_n  = (sr_q >> 1)
              | {d, {(WIDTH-1){1'b0}}};
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_n = DONE;
          diff_n  = sr_n;
          bout_n  = bnext;
`ifdef SERIAL_SUB_OVF_EN
          // d is the final result MSB
          ovf_n   = (am_q != bm_q) && (d != am_q);
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      sa_q    <= sa_n;
      sb_q    <= sb_n;
      sr_q    <= sr_n;
      br_q    <= br_n;
      cnt_q   <= cnt_n;
      diff_q  <= diff_n;
      bout_q  <= bout_n;
`ifdef SERIAL_SUB_OVF_EN
      am_q    <= am_n;
      bm_q    <= bm_n;
      ovf_q   <= ovf_n;
`endif
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed, random, handshake and abort cases.
// Expected values come from plain integer arithmetic on the operands.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
  );
    longint full;
    full = longint'(a) - longint'(b) - longint'(bi);
    d    = full[W-1:0];
    bo   = (full < 0);
  endfunction

`ifdef SERIAL_SUB_OVF_EN
  function automatic logic model_ovf(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         bi
  );
    longint s;
    longint mx;
    longint mn;
    s  = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    mx = (longint'(1) <<< (W-1)) - 1;
    mn = -(longint'(1) <<< (W-1));
    return (s > mx) || (s < mn);
  endfunction
`endif

  task automatic do_op(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         bi,
    input string        nm
  );
    logic [W-1:0] ed;
    logic         eb;
    int           cyc;
    int           nb;
    model(a, b, bi, ed, eb);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bi;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    cyc = 0;
    nb  = 0;
    while (!bus.done && cyc < 4*W) begin
      if (bus.busy) nb++;
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== W) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, cyc, W);
    end
    checks++;
    if (nb !== W) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", nm, nb, W);
    end
    checks++;
    if (bus.diff !== ed) begin
      errors++;
      $display("FAIL %s diff: got %h want %h", nm, bus.diff, ed);
    end
    checks++;
    if (bus.bout !== eb) begin
      errors++;
      $display("FAIL %s bout: got %b want %b", nm, bus.bout, eb);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (bus.ovf !== model_ovf(a, b, bi)) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b", nm, bus.ovf,
               model_ovf(a, b, bi));
    end
`endif
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: done=%b busy=%b want 0 0",
               nm, bus.done, bus.busy);
    end
    checks++;
    if (bus.diff !== ed) begin
      errors++;
      $display("FAIL %s hold: got %h want %h", nm, bus.diff, ed);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h11;
    bus.bin   = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
    checks++;
    if (bus.diff !== '0 || bus.bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: diff=%h bout=%b want 0 0",
               bus.diff, bus.bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", bus.ovf);
    end
`endif
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    do_op(8'h05, 8'h03, 1'b0, "d_05_03");
    do_op(8'h03, 8'h05, 1'b0, "d_03_05");
    do_op(8'h00, 8'h00, 1'b1, "d_00_00_b");
    do_op(8'hFF, 8'h00, 1'b1, "d_FF_00_b");
    do_op(8'hFF, 8'hFF, 1'b1, "d_FF_FF_b");
    do_op(8'h00, 8'hFF, 1'b0, "d_00_FF");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    bus.bin   = 1'b0;
    tick();
    bus.a = 8'h20;
    bus.b = 8'h02;
    cyc = 0;
    while (!bus.done && cyc < 4*W) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== W || bus.diff !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_first: cyc=%0d diff=%h want %0d 0f",
               cyc, bus.diff, W);
    end
    tick();
    bus.start = 1'b0;
    cyc = 1;
    checks++;
    if (bus.busy !== 1'b1 || bus.diff !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_held: busy=%b diff=%h want 1 0f",
               bus.busy, bus.diff);
    end
    while (!bus.done && cyc < 4*W) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== W+1) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want %0d", cyc, W+1);
    end
    checks++;
    if (bus.diff !== 8'h1E || bus.bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: diff=%h bout=%b want 1e 0",
               bus.diff, bus.bout);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int           pulses;
    int           first;
    logic [W-1:0] fd;
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h21;
    bus.bin   = 1'b0;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    first  = -1;
    fd     = '0;
    for (int c = 0; c < 3*W; c++) begin
      if (c == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        pulses++;
        if (first < 0) begin
          first = c;
          fd    = bus.diff;
        end
      end
      tick();
    end
    checks++;
    if (pulses !== 1 || first !== W) begin
      errors++;
      $display("FAIL ignore_pulses: n=%0d at=%0d want 1 at %0d",
               pulses, first, W);
    end
    checks++;
    if (fd !== 8'h39) begin
      errors++;
      $display("FAIL ignore_diff: got %h want 39", fd);
    end
  endtask

  task automatic test_abort();
    int seen;
    do_op(8'h03, 8'h05, 1'b0, "pre_abort");
    bus.start = 1'b1;
    bus.a     = 8'h77;
    bus.b     = 8'h11;
    bus.bin   = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.diff !== '0 || bus.bout !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b diff=%h bout=%b want 0",
               bus.busy, bus.done, bus.diff, bus.bout);
    end
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 2*W; c++) begin
      if (bus.done || bus.busy) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
    end
    do_op(8'h77, 8'h11, 1'b0, "post_abort");
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    do_op(8'h80, 8'h01, 1'b0, "ovf_80_01");
    checks++;
    if (bus.diff !== 8'h7F || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: diff=%h ovf=%b want 7f 1",
               bus.diff, bus.ovf);
    end
    do_op(8'h7F, 8'h01, 1'b0, "ovf_7F_01");
    checks++;
    if (bus.diff !== 8'h7E || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: diff=%h ovf=%b want 7e 0",
               bus.diff, bus.ovf);
    end
  endtask
`endif

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_random();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
